// File: rtl/instr_mem_fetch_if.sv
// Fetch request/response and program-load signals for instr_mem_fetch.
// master drives requests and loads; slave is the memory.
interface instr_mem_fetch_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 128
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                  req_valid;
  logic                  req_ready;
  logic [31:0]           req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_instr;
  logic [31:0]           rsp_addr;
  logic                  rsp_fault;
  logic                  load_start;
  logic [AW-1:0]         load_base;
  logic [AW:0]           load_len;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_busy;
  logic                  load_done;

  modport master (
    output req_valid, req_addr, rsp_ready,
    output load_start, load_base, load_len,
    output load_valid, load_data,
    input  req_ready, rsp_valid, rsp_instr,
    input  rsp_addr, rsp_fault,
    input  load_busy, load_done
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    input  load_start, load_base, load_len,
    input  load_valid, load_data,
    output req_ready, rsp_valid, rsp_instr,
    output rsp_addr, rsp_fault,
    output load_busy, load_done
  );
endinterface

// File: rtl/instr_mem_fetch.sv
// Word-addressed instruction memory: registered fetch plus sequential load.
// Define INSTR_MEM_STATS_EN to add stat_fetches/stat_faults counters.
module instr_mem_fetch #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 128,
  parameter int unsigned           ADDR_LSB   = 2,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input logic              clk,
  input logic              rst,
  instr_mem_fetch_if.slave bus
`ifdef INSTR_MEM_STATS_EN
  ,
  output logic [31:0]      stat_fetches,
  output logic [31:0]      stat_faults
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = AW + 1;
  localparam int unsigned HI = ADDR_LSB + AW;
  localparam logic [31:0] LSB_MASK =
    (32'd1 << ADDR_LSB) - 32'd1;

  typedef enum logic {
    S_READY,
    S_LOAD
  } state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         ptr_q, ptr_d;
  logic [LW-1:0]         rem_q, rem_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_instr_q, rsp_instr_d;
  logic [31:0]           rsp_addr_q, rsp_addr_d;
  logic                  rsp_fault_q, rsp_fault_d;
  logic                  load_busy_q, load_busy_d;
  logic                  load_done_q, load_done_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we;

  logic                  req_ready;
  logic                  accept;
  logic                  misalign;
  logic                  out_of_range;
  logic                  req_fault;
  logic [AW-1:0]         req_idx;

  assign req_ready = (state_q == S_READY)
                   & (~rsp_valid_q | bus.rsp_ready);
  assign accept    = bus.req_valid & req_ready;

  assign misalign     = |(bus.req_addr & LSB_MASK);
  assign out_of_range = |(bus.req_addr >> HI);
  assign req_fault    = misalign | out_of_range;
  assign req_idx      = bus.req_addr[ADDR_LSB +: AW];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    rsp_valid_d = rsp_valid_q;
    rsp_instr_d = rsp_instr_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_fault_d = rsp_fault_q;
    load_busy_d = load_busy_q;
    load_done_d = 1'b0;
    mem_we      = 1'b0;

    // Response register keeps draining regardless of load state
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_addr_d  = bus.req_addr;
      rsp_fault_d = req_fault;
      rsp_instr_d = req_fault ? NOP_WORD
                              : mem_q[req_idx];
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    unique case (state_q)
      S_READY: begin
        if (bus.load_start) begin
          state_d     = S_LOAD;
          ptr_d       = bus.load_base;
          rem_d       = (bus.load_len == '0)
                      ? LW'(DEPTH) : bus.load_len;
          load_busy_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (bus.load_valid) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + AW'(1);
          rem_d  = rem_q - LW'(1);
          if (rem_q == LW'(1)) begin
            state_d     = S_READY;
            load_busy_d = 1'b0;
            load_done_d = 1'b1;
          end
        end
      end
      default: state_d = S_READY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_READY;
      ptr_q       <= '0;
      rem_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= '0;
      rsp_addr_q  <= '0;
      rsp_fault_q <= 1'b0;
      load_busy_q <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_fault_q <= rsp_fault_d;
      load_busy_q <= load_busy_d;
      load_done_q <= load_done_d;
    end
  end

  // Contents survive reset so an aborted load keeps its words
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[ptr_q] <= bus.load_data;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_instr = rsp_instr_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign bus.load_busy = load_busy_q;
  assign bus.load_done = load_done_q;

`ifdef INSTR_MEM_STATS_EN
  logic [31:0] fetches_q, fetches_d;
  logic [31:0] faults_q, faults_d;

  always_comb begin
    fetches_d = fetches_q;
    faults_d  = faults_q;
    if (accept && (fetches_q != '1)) begin
      fetches_d = fetches_q + 32'd1;
    end
    if (accept && req_fault && (faults_q != '1)) begin
      faults_d = faults_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetches_q <= '0;
      faults_q  <= '0;
    end else begin
      fetches_q <= fetches_d;
      faults_q  <= faults_d;
    end
  end

  assign stat_fetches = fetches_q;
  assign stat_faults  = faults_q;
`endif

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Randomized bench for instr_mem_fetch against a word-array model.
// Build with INSTR_MEM_STATS_EN to also check the counters.
module tb_instr_mem_fetch;
  localparam int DW    = 32;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  logic [DW-1:0] ref_mem [DEPTH];

  instr_mem_fetch_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

`ifdef INSTR_MEM_STATS_EN
  logic [31:0] stat_fetches;
  logic [31:0] stat_faults;
`endif

  instr_mem_fetch #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .ADDR_LSB(2),
    .NOP_WORD(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef INSTR_MEM_STATS_EN
    ,
    .stat_fetches(stat_fetches),
    .stat_faults(stat_faults)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  function automatic logic ref_fault(logic [31:0] a);
    return ((a % 4) != 0) || (a >= 32'(DEPTH * 4));
  endfunction

  function automatic logic [DW-1:0] ref_word(logic [31:0] a);
    if (ref_fault(a)) return '0;
    return ref_mem[7'(a / 4)];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.rsp_ready  = 1'b1;
    bus.load_start = 1'b0;
    bus.load_base  = '0;
    bus.load_len   = '0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
  endtask

  task automatic test_reset();
    idle();
    #2 rst = 1'b1;
    #2;
    total_cnt++;
    if (bus.rsp_valid !== 1'b0)
      $display("FAIL reset_rsp_valid got %0b want 0", bus.rsp_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.rsp_instr !== 32'h0)
      $display("FAIL reset_rsp_instr got %h want 0", bus.rsp_instr);
    else pass_cnt++;
    total_cnt++;
    if (bus.rsp_addr !== 32'h0)
      $display("FAIL reset_rsp_addr got %h want 0", bus.rsp_addr);
    else pass_cnt++;
    total_cnt++;
    if (bus.rsp_fault !== 1'b0)
      $display("FAIL reset_rsp_fault got %0b want 0", bus.rsp_fault);
    else pass_cnt++;
    total_cnt++;
    if (bus.load_busy !== 1'b0 || bus.load_done !== 1'b0)
      $display("FAIL reset_load got busy=%0b done=%0b want 0/0",
               bus.load_busy, bus.load_done);
    else pass_cnt++;
    #3 rst = 1'b0;
    step();
    total_cnt++;
    if (bus.req_ready !== 1'b1)
      $display("FAIL reset_req_ready got %0b want 1", bus.req_ready);
    else pass_cnt++;
  endtask

  task automatic test_full_load();
    int base;
    int written;
    int cyc;
    logic [DW-1:0] d;
    idle();
    step();
    base = int'($urandom_range(0, DEPTH - 1));
    bus.load_start = 1'b1;
    bus.load_base  = 7'(base);
    bus.load_len   = '0;
    step();
    bus.load_start = 1'b0;
    total_cnt++;
    if (bus.load_busy !== 1'b1)
      $display("FAIL full_busy got %0b want 1", bus.load_busy);
    else pass_cnt++;
    written = 0;
    cyc = 0;
    while (written < DEPTH && cyc < 1000) begin
      bus.load_valid = ($urandom_range(0, 3) != 0);
      d = $urandom;
      bus.load_data = d;
      if (bus.load_valid) begin
        ref_mem[(base + written) % DEPTH] = d;
        written++;
      end
      step();
      cyc++;
      if (written < DEPTH) begin
        total_cnt++;
        if (bus.load_done !== 1'b0 || bus.load_busy !== 1'b1)
          $display("FAIL full_mid got done=%0b busy=%0b at %0d",
                   bus.load_done, bus.load_busy, written);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (bus.load_done !== 1'b1 || bus.load_busy !== 1'b0)
      $display("FAIL full_end got done=%0b busy=%0b want 1/0",
               bus.load_done, bus.load_busy);
    else pass_cnt++;
    bus.load_valid = 1'b0;
    step();
    total_cnt++;
    if (bus.load_done !== 1'b0)
      $display("FAIL full_done_pulse got %0b want 0", bus.load_done);
    else pass_cnt++;
  endtask

  task automatic test_gapped_load();
    logic [DW-1:0] words [3];
    logic          pat [4];
    int            wi;
    words[0] = 32'h20080064;
    words[1] = 32'h20090006;
    words[2] = 32'h200A000A;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
    idle();
    step();
    bus.load_start = 1'b1;
    bus.load_base  = 7'd0;
    bus.load_len   = 8'd3;
    step();
    bus.load_start = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h0;
    wi = 0;
    for (int k = 0; k < 4; k++) begin
      bus.load_valid = pat[k];
      bus.load_data  = pat[k] ? words[wi] : 32'hDEADBEEF;
      bus.load_start = !pat[k];
      bus.load_base  = 7'd50;
      bus.load_len   = 8'd5;
      #1;
      total_cnt++;
      if (bus.req_ready !== 1'b0 || bus.load_busy !== 1'b1)
        $display("FAIL gap_busy k=%0d got ready=%0b busy=%0b want 0/1",
                 k, bus.req_ready, bus.load_busy);
      else pass_cnt++;
      if (pat[k]) begin
        ref_mem[wi] = words[wi];
        wi++;
      end
      step();
      total_cnt++;
      if (bus.load_done !== (k == 3))
        $display("FAIL gap_done k=%0d got %0b want %0b",
                 k, bus.load_done, (k == 3));
      else pass_cnt++;
    end
    total_cnt++;
    if (bus.load_busy !== 1'b0)
      $display("FAIL gap_busy_end got %0b want 0", bus.load_busy);
    else pass_cnt++;
    idle();
  endtask

  task automatic test_stream();
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      a = 32'(i * 4);
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      bus.rsp_ready = 1'b1;
      #1;
      total_cnt++;
      if (bus.req_ready !== 1'b1)
        $display("FAIL stream_ready i=%0d got %0b want 1",
                 i, bus.req_ready);
      else pass_cnt++;
      step();
      total_cnt++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_addr !== a ||
          bus.rsp_instr !== ref_word(a))
        $display("FAIL stream_rsp i=%0d got v=%0b a=%h d=%h want 1 %h %h",
                 i, bus.rsp_valid, bus.rsp_addr, bus.rsp_instr,
                 a, ref_word(a));
      else pass_cnt++;
    end
    idle();
    step();
    total_cnt++;
    if (bus.rsp_valid !== 1'b0)
      $display("FAIL stream_drain got %0b want 0", bus.rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    idle();
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h4;
    bus.rsp_ready = 1'b0;
    step();
    bus.req_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1 ||
          bus.rsp_instr !== 32'h20090006 || bus.rsp_addr !== 32'h4)
        $display("FAIL stall_hold i=%0d got r=%0b v=%0b d=%h a=%h",
                 i, bus.req_ready, bus.rsp_valid,
                 bus.rsp_instr, bus.rsp_addr);
      else pass_cnt++;
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    total_cnt++;
    if (bus.req_ready !== 1'b1)
      $display("FAIL stall_release got %0b want 1", bus.req_ready);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.rsp_addr !== 32'h8 || bus.rsp_instr !== ref_word(32'h8))
      $display("FAIL stall_next got a=%h d=%h want 8 %h",
               bus.rsp_addr, bus.rsp_instr, ref_word(32'h8));
    else pass_cnt++;
    idle();
    step();
  endtask

  task automatic test_fault();
    logic [31:0] addrs [3];
    addrs[0] = 32'h6;
    addrs[1] = 32'h200;
    addrs[2] = 32'h0;
    idle();
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = addrs[i];
      step();
      total_cnt++;
      if (bus.rsp_valid !== 1'b1 ||
          bus.rsp_fault !== ref_fault(addrs[i]) ||
          bus.rsp_instr !== ref_word(addrs[i]) ||
          bus.rsp_addr !== addrs[i])
        $display("FAIL fault i=%0d got v=%0b f=%0b d=%h a=%h want f=%0b d=%h",
                 i, bus.rsp_valid, bus.rsp_fault, bus.rsp_instr,
                 bus.rsp_addr, ref_fault(addrs[i]), ref_word(addrs[i]));
      else pass_cnt++;
`ifdef INSTR_MEM_STATS_EN
      if (i == 1) begin
        total_cnt++;
        if (stat_faults !== 32'd2 || stat_fetches !== 32'd2)
          $display("FAIL stats_faults got f=%0d n=%0d want 2 2",
                   stat_faults, stat_fetches);
        else pass_cnt++;
      end
`endif
    end
    idle();
    step();
`ifdef INSTR_MEM_STATS_EN
    total_cnt++;
    if (stat_faults !== 32'd2 || stat_fetches !== 32'd3)
      $display("FAIL stats_total got f=%0d n=%0d want 2 3",
               stat_faults, stat_fetches);
    else pass_cnt++;
`endif
  endtask

  task automatic test_wrap();
    logic [31:0] a;
    idle();
    bus.load_start = 1'b1;
    bus.load_base  = 7'd127;
    bus.load_len   = 8'd2;
    step();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = 32'hAAAA0000;
    ref_mem[127]   = 32'hAAAA0000;
    step();
    bus.load_data  = 32'hBBBB0000;
    ref_mem[0]     = 32'hBBBB0000;
    step();
    total_cnt++;
    if (bus.load_done !== 1'b1)
      $display("FAIL wrap_done got %0b want 1", bus.load_done);
    else pass_cnt++;
    idle();
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? 32'h1FC : 32'h0;
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      step();
      total_cnt++;
      if (bus.rsp_instr !== ((i == 0) ? 32'hAAAA0000 : 32'hBBBB0000))
        $display("FAIL wrap_fetch a=%h got %h", a, bus.rsp_instr);
      else pass_cnt++;
    end
    idle();
    step();
  endtask

  task automatic test_load_with_fetch();
    idle();
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h10;
    bus.rsp_ready  = 1'b0;
    bus.load_start = 1'b1;
    bus.load_base  = 7'd20;
    bus.load_len   = 8'd1;
    step();
    bus.load_start = 1'b0;
    total_cnt++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_instr !== ref_word(32'h10) ||
        bus.load_busy !== 1'b1)
      $display("FAIL lwf_accept got v=%0b d=%h busy=%0b want 1 %h 1",
               bus.rsp_valid, bus.rsp_instr, bus.load_busy,
               ref_word(32'h10));
    else pass_cnt++;
    bus.rsp_ready = 1'b1;
    #1;
    total_cnt++;
    if (bus.req_ready !== 1'b0)
      $display("FAIL lwf_ready got %0b want 0", bus.req_ready);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.rsp_valid !== 1'b0)
      $display("FAIL lwf_drain got %0b want 0", bus.rsp_valid);
    else pass_cnt++;
    bus.req_valid  = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = 32'h13579BDF;
    ref_mem[20]    = 32'h13579BDF;
    step();
    total_cnt++;
    if (bus.load_done !== 1'b1)
      $display("FAIL lwf_done got %0b want 1", bus.load_done);
    else pass_cnt++;
    idle();
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'd80;
    step();
    total_cnt++;
    if (bus.rsp_instr !== 32'h13579BDF)
      $display("FAIL lwf_newdata got %h want 13579bdf", bus.rsp_instr);
    else pass_cnt++;
    idle();
    step();
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] a;
    idle();
    bus.load_start = 1'b1;
    bus.load_base  = 7'd40;
    bus.load_len   = 8'd4;
    step();
    bus.load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 32'hC0DE0000 + 32'(i);
      ref_mem[40 + i] = 32'hC0DE0000 + 32'(i);
      step();
    end
    bus.load_valid = 1'b0;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (bus.load_busy !== 1'b0 || bus.load_done !== 1'b0)
      $display("FAIL rml_reset got busy=%0b done=%0b want 0/0",
               bus.load_busy, bus.load_done);
    else pass_cnt++;
    #1 rst = 1'b0;
    step();
    total_cnt++;
    if (bus.req_ready !== 1'b1 || bus.load_done !== 1'b0 ||
        bus.load_busy !== 1'b0)
      $display("FAIL rml_after got r=%0b done=%0b busy=%0b want 1/0/0",
               bus.req_ready, bus.load_done, bus.load_busy);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      a = 32'((40 + i) * 4);
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      step();
      total_cnt++;
      if (bus.rsp_instr !== ref_word(a))
        $display("FAIL rml_fetch a=%h got %h want %h",
                 a, bus.rsp_instr, ref_word(a));
      else pass_cnt++;
    end
    idle();
    step();
  endtask

  task automatic test_random_fetch();
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic        exp_fault;
    logic        exp_ready;
    logic [31:0] a;
    idle();
    step();
    exp_valid = 1'b0;
    exp_addr  = '0;
    exp_instr = '0;
    exp_fault = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) a = $urandom_range(0, 1023);
      else a = 4 * $urandom_range(0, DEPTH - 1);
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.req_addr  = a;
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      #1;
      exp_ready = !exp_valid || bus.rsp_ready;
      total_cnt++;
      if (bus.req_ready !== exp_ready)
        $display("FAIL rnd_ready n=%0d got %0b want %0b",
                 n, bus.req_ready, exp_ready);
      else pass_cnt++;
      if (bus.req_valid && exp_ready) begin
        exp_valid = 1'b1;
        exp_addr  = a;
        exp_fault = ref_fault(a);
        exp_instr = ref_word(a);
      end else if (bus.rsp_ready) begin
        exp_valid = 1'b0;
      end
      step();
      total_cnt++;
      if (bus.rsp_valid !== exp_valid)
        $display("FAIL rnd_valid n=%0d got %0b want %0b",
                 n, bus.rsp_valid, exp_valid);
      else pass_cnt++;
      if (exp_valid) begin
        total_cnt++;
        if (bus.rsp_addr !== exp_addr || bus.rsp_instr !== exp_instr ||
            bus.rsp_fault !== exp_fault)
          $display("FAIL rnd_rsp n=%0d got a=%h d=%h f=%0b want %h %h %0b",
                   n, bus.rsp_addr, bus.rsp_instr, bus.rsp_fault,
                   exp_addr, exp_instr, exp_fault);
        else pass_cnt++;
      end
    end
    idle();
    step();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    idle();
    test_reset();
    test_full_load();
    test_gapped_load();
    test_stream();
    test_stall();
    test_fault();
    test_wrap();
    test_load_with_fetch();
    test_reset_mid_load();
    test_random_fetch();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
